// File: rtl/dmem_resp_pkg.sv
// Shared types and constants for the dmem_resp data-memory response block.
package dmem_resp_pkg;

  localparam int unsigned REG_W           = 64;
  localparam int unsigned MASK_W          = REG_W / 8;
  localparam logic [REG_W-1:0] ZERO_WORD  = '0;
  localparam int unsigned LATENCY_DEFAULT = 2;
  // Wide enough for LATENCY-1 with LATENCY up to 4.
  localparam int unsigned CNT_W           = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic              we;
    logic [REG_W-1:0]  wdata;
    logic [MASK_W-1:0] wmask;
    logic              err;
  } req_t;

endpackage

// File: rtl/dmem_resp_array.sv
// DEPTH x 64 single-port RAM: byte-masked synchronous write, combinational read
// that the parent registers.
module dmem_array
  import dmem_resp_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [REG_W-1:0]  wdata_i,
  input  logic [MASK_W-1:0] wmask_i,
  output logic [REG_W-1:0]  rdata_o
);

  logic [REG_W-1:0] mem_q [DEPTH];

  // NOTE: storage is deliberately left out of reset so it maps onto plain RAM
  // macros; software must write a word before it can trust a load of it.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < MASK_W; i++) begin
        if (wmask_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: one outstanding request, fixed LATENCY from accept to
// response, misaligned requests answered with an error and no array side effect.
module dmem_resp
  import dmem_resp_pkg::*;
#(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = LATENCY_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [REG_W-1:0]  req_addr_i,
  input  logic [REG_W-1:0]  req_wdata_i,
  input  logic [MASK_W-1:0] req_wmask_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [REG_W-1:0]  rsp_rdata_o,
  output logic              rsp_err_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("dmem_resp: LATENCY must be in 1..4");
  end

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  req_t              req_q, req_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [REG_W-1:0]  rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [REG_W-1:0]  arr_rdata;
  logic              accept, fire;
  logic              unused_addr;

  assign unused_addr = ^req_addr_i[REG_W-1:AW+3];
  assign accept      = req_valid_i & req_ready_o;
  assign fire        = (state_q == ST_WAIT) && (cnt_q == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: each combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_valid_i)  state_d = ST_WAIT;
      ST_WAIT: if (cnt_q == '0)  state_d = ST_RESP;
      ST_RESP: if (rsp_ready_i)  state_d = ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    case (state_q)
      ST_IDLE: req_ready_o = 1'b1;
      ST_RESP: rsp_valid_o = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    req_d   = req_q;
    idx_d   = idx_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (accept) begin
      cnt_d = CNT_INIT;
      req_d = '{we:    req_we_i,
                wdata: req_wdata_i,
                wmask: req_wmask_i,
                err:   (req_addr_i[2:0] != 3'd0)};
      idx_d = req_addr_i[AW+2:3];
    end else if (state_q == ST_WAIT && cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    // Stores and misaligned requests always answer with a zero data word.
    if (fire) begin
      err_d   = req_q.err;
      rdata_d = (req_q.we || req_q.err) ? ZERO_WORD : arr_rdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      req_q   <= '0;
      idx_q   <= '0;
      rdata_q <= ZERO_WORD;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      idx_q   <= idx_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk_i   (clk_i),
    .we_i    (fire & req_q.we & ~req_q.err),
    .addr_i  (idx_q),
    .wdata_i (req_q.wdata),
    .wmask_i (req_q.wmask),
    .rdata_o (arr_rdata)
  );

  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Randomized self-checking bench for dmem_resp; instance 0 (LATENCY 2) carries
// the functional traffic, instances 1 and 4-latency builds cover timing.
module tb_dmem_resp;
  import dmem_resp_pkg::*;

  localparam int NI = 3;

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 4);
  endfunction

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, rsp_ready;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wmask;
  logic        req_ready [NI];
  logic        rsp_valid [NI];
  logic        rsp_err   [NI];
  logic [63:0] rsp_rdata [NI];

  int n_checks = 0;
  int n_errors = 0;

  // Reference memory: word contents and whether the word has been fully defined.
  logic [63:0] mdl   [256];
  bit          known [256];

  always #5 clk = ~clk;

  for (genvar k = 0; k < NI; k++) begin : g_dut
    dmem_resp #(.DEPTH(256), .LATENCY(lat_of(k))) u_dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready[k]),
      .req_we_i    (req_we),
      .req_addr_i  (req_addr),
      .req_wdata_i (req_wdata),
      .req_wmask_i (req_wmask),
      .rsp_valid_o (rsp_valid[k]),
      .rsp_ready_i (rsp_ready),
      .rsp_rdata_o (rsp_rdata[k]),
      .rsp_err_o   (rsp_err[k])
    );
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive junk on every request input; legal only while the block is busy.
  task automatic scramble();
    req_valid = 1'($urandom);
    req_we    = 1'($urandom);
    req_addr  = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};
    req_wmask = 8'($urandom);
  endtask

  task automatic do_txn(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [7:0] wmask, input int hold);
    int          n;
    int          idx;
    bit          err;
    bit          chk_data;
    logic [63:0] exp_data;
    idx = int'((addr >> 3) % 256);
    err = (addr % 8) != 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wmask = wmask;
    rsp_ready = 1'b0;
    n = 0;
    while (!req_ready[0] && n < 20) begin @(negedge clk); n++; end
    if (!req_ready[0]) begin
      check("req_ready_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    n = 0;
    while (!rsp_valid[0] && n < 20) begin
      check("busy_req_ready", req_ready[0], 0);
      scramble();
      @(negedge clk);
      n++;
    end
    check("latency", n, 2);
    if (!rsp_valid[0]) begin req_valid = 1'b0; return; end
    chk_data = 1'b1;
    if (we || err)        exp_data = 64'h0;
    else if (known[idx])  exp_data = mdl[idx];
    else begin            exp_data = 64'h0; chk_data = 1'b0; end
    check("rsp_err", rsp_err[0], err);
    if (chk_data) check("rsp_rdata", rsp_rdata[0], exp_data);
    for (int h = 0; h < hold; h++) begin
      scramble();
      @(negedge clk);
      check("hold_valid", rsp_valid[0], 1);
      check("hold_req_ready", req_ready[0], 0);
      if (chk_data) check("hold_rdata", rsp_rdata[0], exp_data);
      check("hold_err", rsp_err[0], err);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post_rsp_valid", rsp_valid[0], 0);
    check("post_rsp_ready", req_ready[0], 1);
    if (we && !err) begin
      for (int i = 0; i < 8; i++)
        if (wmask[i]) mdl[idx][8*i +: 8] = wdata[8*i +: 8];
      if (wmask == 8'hFF) known[idx] = 1'b1;
    end
  endtask

  initial begin
    int          n;
    int          last_acc [NI];
    int          n_acc    [NI];
    bit          prev_v   [NI];
    logic [63:0] a;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_wmask = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_req_ready", req_ready[0], 1);
    check("reset_rsp_valid", rsp_valid[0], 0);
    check("reset_rsp_rdata", rsp_rdata[0], 0);
    check("reset_rsp_err",   rsp_err[0], 0);
    rst = 1'b0;

    for (int w = 0; w < 16; w++) do_txn(1'b1, 64'(w * 8), 64'h0, 8'hFF, 0);

    do_txn(1'b1, 64'h10, 64'h1122334455667788, 8'hFF, 0);
    do_txn(1'b0, 64'h10, 64'h0, 8'h00, 0);
    do_txn(1'b1, 64'h10, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 0);
    do_txn(1'b0, 64'h10, 64'h0, 8'h00, 0);
    do_txn(1'b0, 64'h13, 64'h0, 8'h00, 0);
    do_txn(1'b1, 64'h13, 64'h5555555555555555, 8'hFF, 0);
    do_txn(1'b0, 64'h10, 64'h0, 8'h00, 5);
    do_txn(1'b1, 64'h10, 64'hFFFFFFFFFFFFFFFF, 8'h00, 0);
    do_txn(1'b0, 64'h10, 64'h0, 8'h00, 0);
    do_txn(1'b0, 64'hFFFF_0000_0000_0810, 64'h0, 8'h00, 0);

    // Store 0x20 is accepted, then reset hits while it is still waiting.
    @(negedge clk);
    check("pre_drop_ready", req_ready[0], 1);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 64'h20;
    req_wdata = 64'hDEADBEEFCAFEF00D; req_wmask = 8'hFF;
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b1;
    check("drop_no_rsp", rsp_valid[0], 0);
    @(negedge clk);
    rst = 1'b0;
    check("drop_rsp_valid", rsp_valid[0], 0);
    check("drop_req_ready", req_ready[0], 1);
    check("drop_rsp_rdata", rsp_rdata[0], 0);
    do_txn(1'b0, 64'h20, 64'h0, 8'h00, 0);

    // A load response pending when reset arrives is discarded.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 64'h10;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid[0] && n < 20) begin @(negedge clk); n++; end
    check("resp_rst_valid_before", rsp_valid[0], 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("resp_rst_valid_after", rsp_valid[0], 0);
    check("resp_rst_rdata", rsp_rdata[0], 0);
    check("resp_rst_err", rsp_err[0], 0);

    for (int t = 0; t < 80; t++) begin
      a = {$urandom, $urandom};
      a[10:3] = 8'($urandom_range(0, 15));
      a[2:0]  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      do_txn(1'($urandom), a, {$urandom, $urandom},
             ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom), $urandom_range(0, 3));
    end

    // Back-to-back loads with the response side always ready, all builds at once.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 64'h0; rsp_ready = 1'b1;
    for (int k = 0; k < NI; k++) begin last_acc[k] = 0; n_acc[k] = 0; prev_v[k] = 1'b0; end
    for (int c = 0; c < 60; c++) begin
      for (int k = 0; k < NI; k++) begin
        if (rsp_valid[k] && !prev_v[k] && n_acc[k] > 0)
          check($sformatf("lat%0d_rsp_delay", lat_of(k)), c - last_acc[k], lat_of(k));
        prev_v[k] = rsp_valid[k];
        if (req_ready[k]) begin
          if (n_acc[k] > 0)
            check($sformatf("lat%0d_accept_gap", lat_of(k)), c + 1 - last_acc[k], lat_of(k) + 2);
          last_acc[k] = c + 1;
          n_acc[k]++;
        end
      end
      @(negedge clk);
    end
    for (int k = 0; k < NI; k++)
      check($sformatf("lat%0d_accepts", lat_of(k)), n_acc[k], 60 / (lat_of(k) + 2));
    req_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
